// File: rtl/lemming_dig_arbiter_if.sv
// Bundle of signals between the dig arbiter, the player-input decoder
// and the array of lemming FSMs.
//
// Handshake: the arbiter grants the tool by raising dig_out[i] for exactly
// one cycle. The grantee acknowledges by raising digging[i]. The arbiter
// keeps ownership while digging[i] stays high and drops it when digging[i]
// falls or the dig runs too long. dig_req is a level request with no
// ready/accept: it is sampled only while the arbiter is idle and is never
// queued.
interface lemming_dig_arbiter_if #(
   parameter int N = 4
) ();
   localparam int IW = $clog2(N);

   logic [N-1:0]  dig_req;
   logic [N-1:0]  walking;
   logic [N-1:0]  digging;
   logic [N-1:0]  dig_out;
   logic          busy;
   logic [IW-1:0] owner;
   logic          abort_pulse;
   logic          reclaim_pulse;
   logic [1:0]    dbg_state;

   // Player decoder / lemming array side.
   modport master (
      output dig_req, walking, digging,
      input  dig_out, busy, owner, abort_pulse, reclaim_pulse, dbg_state
   );

   // Arbiter side.
   modport slave (
      input  dig_req, walking, digging,
      output dig_out, busy, owner, abort_pulse, reclaim_pulse, dbg_state
   );
endinterface

// File: rtl/lemming_dig_arbiter.sv
// Round-robin arbiter for the single shared dig tool. One lemming owns the
// tool at a time. Ownership is granted with a one-cycle dig pulse, kept while
// the owner reports digging, and reclaimed when digging stops, when the
// grantee never acknowledges, or when a dig overruns MAX_DIG cycles.
// All outputs are registered. The FSM state is exported on bus.dbg_state.
module lemming_dig_arbiter #(
   parameter int N           = 4,
   parameter int ACK_TIMEOUT = 2,
   parameter int MAX_DIG     = 16
) (
   input logic                 clk,
   input logic                 rst,
   lemming_dig_arbiter_if.slave bus
);
   localparam int IW   = $clog2(N);
   localparam int CMAX = (ACK_TIMEOUT > MAX_DIG) ? ACK_TIMEOUT : MAX_DIG;
   localparam int CW   = $clog2(CMAX) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      DIG     = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [N-1:0]  dig_out_q, dig_out_d;
   logic          busy_q, busy_d;
   logic          abort_q, abort_d;
   logic          reclaim_q, reclaim_d;

   logic [N-1:0]  eligible;
   logic          found;
   logic [IW-1:0] winner;
   logic [IW-1:0] idx;
   logic [IW-1:0] owner_next;

   assign eligible   = bus.dig_req & bus.walking;
   assign owner_next = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

   // Rotating priority search: first eligible index at or after ptr, wrapping.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = 0; i < N; i++) begin
         idx = IW'((int'(ptr_q) + i) % N);
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      owner_d   = owner_q;
      dig_out_d = '0;
      abort_d   = 1'b0;
      reclaim_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d   = GRANT;
               owner_d   = winner;
               dig_out_d = N'(1) << winner;
               cnt_d     = '0;
            end
         end
         GRANT: begin
            if (bus.digging[owner_q]) begin
               state_d = DIG;
               cnt_d   = '0;
            end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
               state_d = IDLE;
               abort_d = 1'b1;
               ptr_d   = owner_next;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DIG: begin
            // A fall on the same cycle as the limit is a normal release.
            if (!bus.digging[owner_q]) begin
               state_d = RELEASE;
               cnt_d   = '0;
            end else if (cnt_q == CW'(MAX_DIG - 1)) begin
               state_d   = RELEASE;
               reclaim_d = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            state_d = IDLE;
            ptr_d   = owner_next;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset overrides every event.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         owner_q   <= '0;
         dig_out_q <= '0;
         busy_q    <= 1'b0;
         abort_q   <= 1'b0;
         reclaim_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         owner_q   <= owner_d;
         dig_out_q <= dig_out_d;
         busy_q    <= busy_d;
         abort_q   <= abort_d;
         reclaim_q <= reclaim_d;
      end
   end

   assign bus.dig_out       = dig_out_q;
   assign bus.busy          = busy_q;
   assign bus.owner         = owner_q;
   assign bus.abort_pulse   = abort_q;
   assign bus.reclaim_pulse = reclaim_q;
   assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_lemming_dig_arbiter.sv
// Self-checking bench for lemming_dig_arbiter. A transaction-level model
// predicts the winner, the outcome (dig, abort or reclaim) and how long the
// tool stays busy; a monitor pops predicted events as the DUT emits them.
module tb_lemming_dig_arbiter;
   localparam int N  = 4;
   localparam int AT = 2;
   localparam int MD = 16;

   localparam logic [3:0] EV_GRANT   = 4'd1;
   localparam logic [3:0] EV_ABORT   = 4'd2;
   localparam logic [3:0] EV_RECLAIM = 4'd3;

   logic clk;
   logic rst;

   lemming_dig_arbiter_if #(.N(N)) bus ();

   lemming_dig_arbiter #(.N(N), .ACK_TIMEOUT(AT), .MAX_DIG(MD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_cmp = 0;
   int         n_err = 0;
   int         m_ptr = 0;
   logic [7:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before 500000");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ev(input logic [3:0] kind, input int idx);
      return {kind, 4'(idx)};
   endfunction

   // First eligible lemming at or after the model pointer, wrapping.
   function automatic int model_winner(input logic [N-1:0] elig);
      for (int k = 0; k < N; k++) begin
         if (elig[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic pop_cmp(input string name, input logic [7:0] act);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s: got event %0h expected no event", name, act);
      end else begin
         check(name, int'(act), int'(exp_q.pop_front()));
      end
   endtask

   // ---------------- monitor ----------------
   logic [N-1:0] prev_dig = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.dig_out != '0) begin
            int gi;
            gi = 0;
            for (int i = N - 1; i >= 0; i--) if (bus.dig_out[i]) gi = i;
            check("dig_onehot", $countones(bus.dig_out), 1);
            check("dig_single_cycle", int'(prev_dig != '0), 0);
            check("grant_owner", int'(bus.owner), gi);
            pop_cmp("grant_event", ev(EV_GRANT, gi));
         end
         if (bus.abort_pulse) pop_cmp("abort_event", ev(EV_ABORT, int'(bus.owner)));
         if (bus.reclaim_pulse) pop_cmp("reclaim_event", ev(EV_RECLAIM, int'(bus.owner)));
         prev_dig = bus.dig_out;
      end else begin
         prev_dig = '0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_grant(output bit got);
      got = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.dig_out != '0) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL grant_timeout: got no dig_out expected a grant");
      end
   endtask

   // One request round. d = cycles after the grant pulse before the grantee
   // acks (d >= AT means it never acks); L = cycles digging stays high.
   task automatic run_txn(input logic [N-1:0] req, input logic [N-1:0] walk,
                          input int d, input int L);
      logic [N-1:0] elig;
      int  w, exp_len, len;
      bit  abort, reclaim, got, counting;
      bus.dig_req = req;
      bus.walking = walk;
      elig = req & walk;
      if (elig == '0) begin
         repeat (6) @(negedge clk);
         check("no_grant_busy", int'(bus.busy), 0);
         bus.dig_req = '0;
         return;
      end
      w       = model_winner(elig);
      abort   = (d >= AT);
      reclaim = !abort && (L > MD);
      exp_q.push_back(ev(EV_GRANT, w));
      if (abort)   exp_q.push_back(ev(EV_ABORT, w));
      if (reclaim) exp_q.push_back(ev(EV_RECLAIM, w));
      exp_len = abort ? AT : d + ((L < MD) ? L : MD) + 2;
      wait_grant(got);
      bus.dig_req = '0;
      if (!got) begin
         exp_q.delete();
         return;
      end
      bus.walking = N'($urandom);
      len = 0;
      counting = 1'b1;
      for (int c = 0; c < 200; c++) begin
         if (c > 0) @(negedge clk);
         if (counting) begin
            if (bus.busy) len++;
            else counting = 1'b0;
         end
         if (!abort && c == exp_len - 1)
            check("release_state", int'(bus.dbg_state), 3);
         bus.digging = (!abort && c >= d && c < d + L) ? (N'(1) << w) : '0;
         if (!counting && (abort || c >= d + L)) break;
      end
      bus.digging = '0;
      check("busy_len", len, exp_len);
      m_ptr = (w + 1) % N;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit got;
      bus.dig_req = '1;
      bus.walking = '1;
      bus.digging = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_dig_out", int'(bus.dig_out), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_owner", int'(bus.owner), 0);
      check("rst_abort", int'(bus.abort_pulse), 0);
      check("rst_reclaim", int'(bus.reclaim_pulse), 0);
      check("rst_state", int'(bus.dbg_state), 0);
      bus.dig_req = '0;
      rst = 1'b0;

      // First grant after reset, then a single request with timed digging.
      run_txn(4'b1111, 4'b1111, 0, 3);
      run_txn(4'b0100, 4'b1111, 1, 5);
      // Round robin with everyone asking.
      repeat (5) run_txn(4'b1111, 4'b1111, 0, 3);
      // Grantee never acks.
      run_txn(4'b0010, 4'b1111, AT, 0);
      run_txn(4'b1111, 4'b1111, 0, 2);
      // Overrun and the limit boundaries.
      run_txn(4'b0001, 4'b1111, 0, 30);
      run_txn(4'b1000, 4'b1111, 0, MD);
      run_txn(4'b1111, 4'b1111, 1, MD + 1);
      run_txn(4'b1111, 4'b1111, 1, MD);
      run_txn(4'b1111, 4'b1111, 0, MD - 1);

      // Randomized rounds.
      for (int t = 0; t < 40; t++) begin
         logic [N-1:0] rq, wk;
         int d, L;
         rq = N'($urandom);
         wk = N'($urandom) | N'($urandom);
         d  = ($urandom_range(0, 5) == 0) ? AT : int'($urandom_range(0, AT - 1));
         case ($urandom_range(0, 3))
            0:       L = MD - 1 + int'($urandom_range(0, 2));
            1:       L = MD + int'($urandom_range(1, 6));
            default: L = int'($urandom_range(1, 8));
         endcase
         run_txn(rq, wk, d, L);
      end

      // Reset in the middle of a dig.
      bus.dig_req = 4'b0100;
      bus.walking = '1;
      exp_q.push_back(ev(EV_GRANT, model_winner(4'b0100)));
      wait_grant(got);
      bus.dig_req = '0;
      bus.digging = 4'b0100;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_owner", int'(bus.owner), 0);
      check("midrst_state", int'(bus.dbg_state), 0);
      check("midrst_dig_out", int'(bus.dig_out), 0);
      exp_q.delete();
      m_ptr = 0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      bus.digging = '0;

      // Requests from non-walking lemmings are never granted.
      bus.dig_req = 4'b0010;
      bus.walking = 4'b0000;
      repeat (20) @(negedge clk);
      check("inelig_busy", int'(bus.busy), 0);
      bus.dig_req = '0;
      @(negedge clk);

      // Pointer was reset: everyone asking goes to lemming 0.
      run_txn(4'b1111, 4'b1111, 0, 2);
      repeat (3) @(negedge clk);

      check("exp_q_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
